shadow_register_file: RTL
=========================

Name: shadow_register_file

Overview:
- Parametrised successor to the panel-control register file.
- Host-side writes land in shadow registers. Timing-critical outputs (integration time, bias select, ROI window, idle/bias mode) update only on a commit synchronised to a frame boundary, so readout never sees a half-updated configuration.
- Adds sticky edge-detected interrupts with W1C and mask, a read-valid handshake, access-error flagging, and window validation.
- Sits between the host bus bridge and the panel timing/readout controllers.

Parameters:
- DATA_W, 32: register data width (≥ 28).
- ADDR_W, 8: register address width.
- IRQ_W, 8: number of interrupt sources.
- WIN_W, 12: ROI coordinate width.
- ROWS, 2048: panel rows; row_end must be < ROWS.
- COLS, 2048: panel columns; col_end must be < COLS.
- INT_TIME_RST, 1000: integration_time reset value.
- VERSION, 32'h0002_0000: value of the VERSION register.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- reg_addr  in  ADDR_W  register address
- reg_wdata  in  DATA_W  write data
- reg_write  in  1  write strobe, one access per cycle
- reg_read  in  1  read strobe
- reg_rdata  out  DATA_W  read data, valid with reg_rvalid
- reg_rvalid  out  1  read-data-valid pulse
- reg_err  out  1  access-error pulse
- frame_boundary  in  1  single-cycle pulse marking frame end
- frame_busy, fifo_empty, fifo_full, bias_ready  in  1 each  status inputs
- irq_raw  in  IRQ_W  level interrupt sources
- integration_time  out  16  active
- bias_sel  out  3  active
- bias_mode_select  out  2  active
- idle_mode  out  1  active
- row_start, row_end, col_start, col_end  out  WIN_W each  active ROI
- frame_start, frame_reset  out  1  single-cycle pulses
- commit_done  out  1  pulse when active registers are updated
- irq_out  out  1  OR of masked interrupt status

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset values:
  - Shadow and active registers: 0, except integration_time = INT_TIME_RST, row_end = ROWS-1, col_end = COLS-1.
  - All pulse outputs, reg_rdata, irq mask/status and commit_pending: 0.
- Register map:
  - 0x00 CTRL: [0] frame_start (W, self-clearing); [1] frame_reset (W, self-clearing); [2] idle_mode (shadowed); [4:3] bias_mode (shadowed).
  - 0x01 STATUS (RO): [0] frame_busy; [1] fifo_empty; [2] fifo_full; [3] bias_ready; [4] commit_pending; [5] commit_fail.
  - 0x02 BIAS_SEL: [2:0], shadowed.
  - 0x03 INT_TIME: [15:0], shadowed.
  - 0x04 ROW_WIN: [WIN_W-1:0] start, [16+WIN_W-1:16] end, shadowed.
  - 0x05 COL_WIN: same layout, shadowed.
  - 0x06 IRQ_MASK: immediate.
  - 0x07 IRQ_STATUS: W1C.
  - 0x08 COMMIT: [0] arm, [1] force.
  - 0x09 VERSION (RO).
- Reads of shadowed registers return the shadow value; unused bits read 0.
- Write timing: data captured on the edge where reg_write=1; the shadow is visible to a read the next cycle.
- Read timing: reg_rdata and reg_rvalid are registered, 1-cycle latency. reg_rvalid=1 for exactly one cycle per reg_read.
- reg_write and reg_read in the same cycle: both are performed; the read returns the pre-write value.
- reg_err (1-cycle pulse, registered) fires on:
  - access to an unmapped address (such reads also return 0);
  - a write to a RO register (write ignored);
  - a CTRL write with bit0=1 while frame_busy=1 (frame_start suppressed; other CTRL fields still written).
- frame_start / frame_reset: pulse high for 1 cycle, the cycle after the CTRL write.
- Commit FSM, states IDLE / PENDING:
  - COMMIT write with arm=1 → PENDING (commit_pending=1).
  - In PENDING, on frame_boundary, all shadows are copied to active, commit_done pulses and the FSM returns to IDLE.
  - COMMIT write with force=1 performs the copy on the next cycle regardless of frame_boundary, from IDLE or PENDING.
  - A COMMIT arm write coinciding with frame_boundary does not commit on that boundary; it waits for the next one.
  - A shadow write in the commit cycle is not copied (active receives the prior shadow) and remains in the shadow.
  - Re-arming while PENDING has no extra effect.
- Window validation at commit: if row_start>row_end, col_start>col_end, row_end≥ROWS or col_end≥COLS:
  - no active register changes, and commit_done does not pulse;
  - commit_fail=1, FSM returns to IDLE;
  - commit_fail clears on the next successful commit.
- Interrupts:
  - irq_status[i] sets on a rising edge of irq_raw[i], detected against a registered previous value (which resets to 0).
  - Cleared by writing 1 to bit i of 0x07; a set and a clear in the same cycle leave the bit set.
  - irq_out = |(irq_status & irq_mask), driven from registered state.
- Reset asserted mid-operation returns every register and the FSM to the reset values on that edge; a pending commit is discarded.

Test Plan:
- Reset, read 0x03 and 0x04 → integration_time=1000, ROW_WIN=0x07FF_0000, reg_rvalid one cycle after reg_read, reg_err=0.
- Write INT_TIME=500, read back → 500 while integration_time stays 1000; arm COMMIT, pulse frame_boundary 10 cycles later → integration_time=500 the cycle after the boundary, commit_done pulses once, STATUS[4] returns to 0.
- Write ROW_WIN start=100 end=50, COMMIT force → row_start/row_end unchanged, STATUS[5]=1, no commit_done; rewrite start=10 end=50 and force → active updates, STATUS[5]=0.
- IRQ_MASK=0x01, raise irq_raw[0] → irq_status=0x01, irq_out=1; hold irq_raw high and write 0x07=0x01 → status 0 and no re-set; drop and re-raise irq_raw[0] in the same cycle as a W1C write → bit stays 1.
- With frame_busy=1, write CTRL=0x05 → reg_err pulse, no frame_start, shadow idle_mode=1; with frame_busy=0, write CTRL=0x01 → frame_start high for exactly one cycle.
- Read 0x20 → reg_rdata=0 with reg_err pulse; read 0x09 → VERSION; assert rst_n=0 while PENDING → commit_pending=0 and all outputs at reset values.

Source files
------------

// File: rtl/shadow_register_file.sv
// Host-facing register file: writes land in shadow registers and reach the active
// panel configuration only through a frame-synchronised (or forced) commit.
module shadow_register_file #(
  parameter int          DATA_W       = 32,
  parameter int          ADDR_W       = 8,
  parameter int          IRQ_W        = 8,
  parameter int          WIN_W        = 12,
  parameter int          ROWS         = 2048,
  parameter int          COLS         = 2048,
  parameter int          INT_TIME_RST = 1000,
  parameter logic [31:0] VERSION      = 32'h0002_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0] reg_wdata,
  input  logic              reg_write,
  input  logic              reg_read,
  output logic [DATA_W-1:0] reg_rdata,
  output logic              reg_rvalid,
  output logic              reg_err,
  input  logic              frame_boundary,
  input  logic              frame_busy,
  input  logic              fifo_empty,
  input  logic              fifo_full,
  input  logic              bias_ready,
  input  logic [IRQ_W-1:0]  irq_raw,
  output logic [15:0]       integration_time,
  output logic [2:0]        bias_sel,
  output logic [1:0]        bias_mode_select,
  output logic              idle_mode,
  output logic [WIN_W-1:0]  row_start,
  output logic [WIN_W-1:0]  row_end,
  output logic [WIN_W-1:0]  col_start,
  output logic [WIN_W-1:0]  col_end,
  output logic              frame_start,
  output logic              frame_reset,
  output logic              commit_done,
  output logic              irq_out
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PENDING = 1'b1} state_e;

  localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_BIAS    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_INT     = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_ROW     = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_COL     = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_MASK    = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] A_ISTAT   = ADDR_W'(7);
  localparam logic [ADDR_W-1:0] A_COMMIT  = ADDR_W'(8);
  localparam logic [ADDR_W-1:0] A_VERSION = ADDR_W'(9);
  localparam logic [WIN_W:0]    ROWS_L    = (WIN_W+1)'(ROWS);
  localparam logic [WIN_W:0]    COLS_L    = (WIN_W+1)'(COLS);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               rvalid_q, err_q, err_d;
  logic               sh_idle_q, ac_idle_q;
  logic [1:0]         sh_bmode_q, ac_bmode_q;
  logic [2:0]         sh_bias_q, ac_bias_q;
  logic [15:0]        sh_int_q, ac_int_q;
  logic [WIN_W-1:0]   sh_rs_q, sh_re_q, sh_cs_q, sh_ce_q;
  logic [WIN_W-1:0]   ac_rs_q, ac_re_q, ac_cs_q, ac_ce_q;
  logic               force_q, commit_fail_q, commit_done_q, fs_q, fr_q, irq_out_q;
  logic [IRQ_W-1:0]   irq_mask_q, irq_mask_d, irq_stat_q, irq_stat_d, irq_prev_q, irq_clr_s;
  logic               wr_ctrl_s, wr_ro_s, mapped_s, start_err_s, arm_s, force_wr_s;
  logic               commit_go_s, win_ok_s, commit_ok_s, unused_s;

  assign unused_s    = ^reg_wdata;
  assign wr_ctrl_s   = reg_write & (reg_addr == A_CTRL);
  assign wr_ro_s     = reg_write & ((reg_addr == A_STATUS) | (reg_addr == A_VERSION));
  assign mapped_s    = (reg_addr <= A_VERSION);
  assign start_err_s = wr_ctrl_s & reg_wdata[0] & frame_busy;
  assign arm_s       = reg_write & (reg_addr == A_COMMIT) & reg_wdata[0];
  assign force_wr_s  = reg_write & (reg_addr == A_COMMIT) & reg_wdata[1];
  assign err_d       = ((reg_write | reg_read) & ~mapped_s) | wr_ro_s | start_err_s;

  // The commit samples the shadows as they stand before any same-cycle write.
  assign commit_go_s = force_q | ((state_q == ST_PENDING) & frame_boundary);
  assign win_ok_s    = (sh_rs_q <= sh_re_q) & (sh_cs_q <= sh_ce_q) &
                       ({1'b0, sh_re_q} < ROWS_L) & ({1'b0, sh_ce_q} < COLS_L);
  assign commit_ok_s = commit_go_s & win_ok_s;

  assign irq_clr_s   = (reg_write & (reg_addr == A_ISTAT)) ? reg_wdata[IRQ_W-1:0] : '0;
  assign irq_stat_d  = (irq_stat_q & ~irq_clr_s) | (irq_raw & ~irq_prev_q);
  assign irq_mask_d  = (reg_write & (reg_addr == A_MASK)) ? reg_wdata[IRQ_W-1:0] : irq_mask_q;

  // Commit FSM next state: a commit attempt always returns to idle.
  always_comb begin
    state_d = state_q;
    if (commit_go_s) begin
      state_d = ST_IDLE;
    end else if (arm_s) begin
      state_d = ST_PENDING;
    end else begin
      state_d = state_q;
    end
  end

  // Read mux over the pre-write register contents.
  always_comb begin
    rdata_d = '0;
    case (reg_addr)
      A_CTRL:    begin rdata_d[2] = sh_idle_q; rdata_d[4:3] = sh_bmode_q; end
      A_STATUS:  rdata_d[5:0] = {commit_fail_q, (state_q == ST_PENDING), bias_ready,
                                 fifo_full, fifo_empty, frame_busy};
      A_BIAS:    rdata_d[2:0] = sh_bias_q;
      A_INT:     rdata_d[15:0] = sh_int_q;
      A_ROW:     begin rdata_d[WIN_W-1:0] = sh_rs_q; rdata_d[16 +: WIN_W] = sh_re_q; end
      A_COL:     begin rdata_d[WIN_W-1:0] = sh_cs_q; rdata_d[16 +: WIN_W] = sh_ce_q; end
      A_MASK:    rdata_d[IRQ_W-1:0] = irq_mask_q;
      A_ISTAT:   rdata_d[IRQ_W-1:0] = irq_stat_q;
      A_VERSION: rdata_d = DATA_W'(VERSION);
      default:   rdata_d = '0;
    endcase
  end

  // All state: bus responses, shadows, active set, commit control and interrupts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;     rdata_q <= '0;          rvalid_q <= 1'b0;   err_q <= 1'b0;
      sh_idle_q <= 1'b0;      sh_bmode_q <= 2'd0;     sh_bias_q <= 3'd0;
      sh_int_q <= 16'(INT_TIME_RST);
      sh_rs_q <= '0; sh_re_q <= WIN_W'(ROWS-1); sh_cs_q <= '0; sh_ce_q <= WIN_W'(COLS-1);
      ac_idle_q <= 1'b0;      ac_bmode_q <= 2'd0;     ac_bias_q <= 3'd0;
      ac_int_q <= 16'(INT_TIME_RST);
      ac_rs_q <= '0; ac_re_q <= WIN_W'(ROWS-1); ac_cs_q <= '0; ac_ce_q <= WIN_W'(COLS-1);
      force_q <= 1'b0; commit_fail_q <= 1'b0; commit_done_q <= 1'b0;
      fs_q <= 1'b0; fr_q <= 1'b0; irq_out_q <= 1'b0;
      irq_mask_q <= '0; irq_stat_q <= '0; irq_prev_q <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= reg_read;
      rdata_q  <= reg_read ? rdata_d : '0;
      err_q    <= err_d;
      fs_q     <= wr_ctrl_s & reg_wdata[0] & ~frame_busy;
      fr_q     <= wr_ctrl_s & reg_wdata[1];
      force_q  <= force_wr_s;
      commit_done_q <= commit_ok_s;
      if (commit_go_s) commit_fail_q <= ~win_ok_s;
      if (commit_ok_s) begin
        ac_idle_q <= sh_idle_q; ac_bmode_q <= sh_bmode_q; ac_bias_q <= sh_bias_q;
        ac_int_q  <= sh_int_q;
        ac_rs_q <= sh_rs_q; ac_re_q <= sh_re_q; ac_cs_q <= sh_cs_q; ac_ce_q <= sh_ce_q;
      end
      if (wr_ctrl_s) begin
        sh_idle_q  <= reg_wdata[2];
        sh_bmode_q <= reg_wdata[4:3];
      end
      if (reg_write && reg_addr == A_BIAS) sh_bias_q <= reg_wdata[2:0];
      if (reg_write && reg_addr == A_INT)  sh_int_q  <= reg_wdata[15:0];
      if (reg_write && reg_addr == A_ROW) begin
        sh_rs_q <= reg_wdata[WIN_W-1:0];
        sh_re_q <= reg_wdata[16 +: WIN_W];
      end
      if (reg_write && reg_addr == A_COL) begin
        sh_cs_q <= reg_wdata[WIN_W-1:0];
        sh_ce_q <= reg_wdata[16 +: WIN_W];
      end
      irq_prev_q <= irq_raw;
      irq_stat_q <= irq_stat_d;
      irq_mask_q <= irq_mask_d;
      irq_out_q  <= |(irq_stat_d & irq_mask_d);
    end
  end

  assign reg_rdata        = rdata_q;
  assign reg_rvalid       = rvalid_q;
  assign reg_err          = err_q;
  assign integration_time = ac_int_q;
  assign bias_sel         = ac_bias_q;
  assign bias_mode_select = ac_bmode_q;
  assign idle_mode        = ac_idle_q;
  assign row_start        = ac_rs_q;
  assign row_end          = ac_re_q;
  assign col_start        = ac_cs_q;
  assign col_end          = ac_ce_q;
  assign frame_start      = fs_q;
  assign frame_reset      = fr_q;
  assign commit_done      = commit_done_q;
  assign irq_out          = irq_out_q;

endmodule
